pipe_issue_collect: RTL and testbench

Issue-and-collect front end for a fixed-latency, non-stalling arithmetic pipeline. It accepts operand pairs over a valid/ready handshake, drives them into the pipeline through registered operand outputs, and tracks every in-flight operation. Each returning result is captured into a small output FIFO, and results leave the block through a second valid/ready handshake. Credit accounting guarantees that no result is ever dropped, even though the pipeline itself cannot be stalled.

---
 rtl/pipe_issue_collect.sv | 104 ++++++++++
 tb/tb_pipe_issue_collect.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_issue_collect.sv
// Issue/collect front end for a fixed-latency, non-stalling pipeline.
// Credits cover in-flight work plus buffered results so none is dropped.
module pipe_issue_collect #(
    parameter int DWIDTH = 8,
    parameter int LAT    = 4,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [DWIDTH-1:0]          op1_i,
    input  logic [DWIDTH-1:0]          op2_i,
    output logic [DWIDTH-1:0]          pipe_op1_o,
    output logic [DWIDTH-1:0]          pipe_op2_o,
    input  logic [DWIDTH-1:0]          pipe_res_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [DWIDTH-1:0]          res_o,
    output logic [$clog2(LAT+1)-1:0]   inflight_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int IW = $clog2(LAT+1);
    localparam int CW = $clog2(DEPTH+1);
    localparam int AW = $clog2(DEPTH);

    logic [LAT-1:0]    vld_q;
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [31:0]       occ;
    logic              accept;
    logic              capture;
    logic              pop;

    assign accept      = in_valid_i && in_ready_o;
    assign capture     = vld_q[LAT-1];
    assign out_valid_o = (count_q != '0);
    assign pop         = out_valid_o && out_ready_i;
    assign count_o     = count_q;
    // memory is not reset, so an empty FIFO shows 0 at the head
    assign res_o       = out_valid_o ? mem_q[rd_ptr_q] : '0;

    // in-flight count is the number of set token bits
    always_comb begin
        inflight_o = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight_o = inflight_o + IW'(vld_q[i]);
        end
    end

    // credit check from registered state only; same-cycle pops ignored
    always_comb begin
        occ        = 32'(count_q) + 32'(inflight_o);
        in_ready_o = (occ < 32'(DEPTH));
    end

    // token shift register tracks each accepted op through the pipe
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= (vld_q << 1) | LAT'(accept);
        end
    end

    // operand registers feeding the pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_op1_o <= '0;
            pipe_op2_o <= '0;
        end else if (accept) begin
            pipe_op1_o <= op1_i;
            pipe_op2_o <= op2_i;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (capture) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({capture, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // result storage; a capture never targets a full FIFO
    always_ff @(posedge clk) begin
        if (!rst && capture) begin
            mem_q[wr_ptr_q] <= pipe_res_i;
        end
    end

endmodule

// File: tb/tb_pipe_issue_collect.sv
// Directed bench: DEPTH=8 instance (a) and DEPTH=4 instance (b),
// each fed by a 3-register op1+op2 model pipeline.
module tb_pipe_issue_collect;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] op1;
    logic [7:0] op2;

    logic       rdy_a, ov_a, rdy_b, ov_b;
    logic [7:0] po1_a, po2_a, pres_a, res_a;
    logic [7:0] po1_b, po2_b, pres_b, res_b;
    logic [2:0] infl_a, infl_b;
    logic [3:0] cnt_a;
    logic [2:0] cnt_b;
    logic [7:0] sa1, sa2, sb1, sb2;

    int n_cmp = 0;
    int n_err = 0;
    int acc;

    pipe_issue_collect #(.DWIDTH(8), .LAT(4), .DEPTH(8)) u_a (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid), .in_ready_o(rdy_a),
        .op1_i(op1), .op2_i(op2),
        .pipe_op1_o(po1_a), .pipe_op2_o(po2_a),
        .pipe_res_i(pres_a),
        .out_valid_o(ov_a), .out_ready_i(out_ready),
        .res_o(res_a), .inflight_o(infl_a), .count_o(cnt_a)
    );

    pipe_issue_collect #(.DWIDTH(8), .LAT(4), .DEPTH(4)) u_b (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid), .in_ready_o(rdy_b),
        .op1_i(op1), .op2_i(op2),
        .pipe_op1_o(po1_b), .pipe_op2_o(po2_b),
        .pipe_res_i(pres_b),
        .out_valid_o(ov_b), .out_ready_i(out_ready),
        .res_o(res_b), .inflight_o(infl_b), .count_o(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model pipelines: op1+op2 through three registers
    always @(posedge clk) begin
        sa1 <= po1_a + po2_a;
        sa2 <= sa1;
        pres_a <= sa2;
        sb1 <= po1_b + po2_b;
        sb2 <= sb1;
        pres_b <= sb2;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op1 = '0; op2 = '0;
        step(); step();

        chk("rst_rdy_a", 32'(rdy_a), 1);
        chk("rst_ov_a", 32'(ov_a), 0);
        chk("rst_cnt_a", 32'(cnt_a), 0);
        chk("rst_infl_a", 32'(infl_a), 0);
        chk("rst_po1_a", 32'(po1_a), 0);
        chk("rst_res_a", 32'(res_a), 0);
        chk("rst_rdy_b", 32'(rdy_b), 1);
        chk("rst_cnt_b", 32'(cnt_b), 0);
        rst = 1'b0;

        // single operation (5,3)
        in_valid = 1'b1; op1 = 8'd5; op2 = 8'd3;
        step();
        in_valid = 1'b0;
        chk("one_po1", 32'(po1_a), 5);
        chk("one_infl", 32'(infl_a), 1);
        step(); step(); step();
        chk("one_ov_early", 32'(ov_a), 0);
        step();
        chk("one_ov", 32'(ov_a), 1);
        chk("one_res", 32'(res_a), 8);
        chk("one_cnt", 32'(cnt_a), 1);
        chk("one_infl0", 32'(infl_a), 0);
        out_ready = 1'b1;
        step();
        chk("one_pop_cnt", 32'(cnt_a), 0);
        chk("one_pop_ov", 32'(ov_a), 0);

        // back-to-back, DEPTH=8, pointers wrap
        for (int c = 0; c <= 16; c++) begin
            chk("b2b_ov", 32'(ov_a), (c >= 5 && c <= 14) ? 1 : 0);
            if (c >= 5 && c <= 14)
                chk("b2b_res", 32'(res_a), 32'(2 * (c - 5)));
            if (c < 10) begin
                chk("b2b_rdy", 32'(rdy_a), 1);
                in_valid = 1'b1; op1 = 8'(c); op2 = 8'(c);
            end else begin
                in_valid = 1'b0;
            end
            step();
        end
        chk("b2b_cnt_end", 32'(cnt_a), 0);

        // backpressure on DEPTH=4
        out_ready = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        acc = 0;
        for (int c = 0; c < 12; c++) begin
            chk("bp_rdy", 32'(rdy_b), (c < 4) ? 1 : 0);
            if (rdy_b) acc++;
            in_valid = 1'b1;
            op1 = (c < 4) ? 8'(c + 1) : 8'd99;
            op2 = (c < 4) ? 8'(2 * c) : 8'd99;
            step();
        end
        in_valid = 1'b0;
        chk("bp_accepts", 32'(acc), 4);
        chk("bp_cnt", 32'(cnt_b), 4);
        chk("bp_infl", 32'(infl_b), 0);
        chk("bp_rdy_full", 32'(rdy_b), 0);
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk("bp_ov", 32'(ov_b), 1);
            chk("bp_res", 32'(res_b), 32'(3 * j + 1));
            step();
            if (j == 0) chk("bp_rdy_back", 32'(rdy_b), 1);
        end
        chk("bp_empty_cnt", 32'(cnt_b), 0);
        chk("bp_empty_ov", 32'(ov_b), 0);
        out_ready = 1'b0;

        // simultaneous capture and pop
        in_valid = 1'b1; op1 = 8'd2; op2 = 8'd2;
        step();
        op1 = 8'd3; op2 = 8'd3;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        chk("sim_cnt_pre", 32'(cnt_b), 1);
        chk("sim_res_pre", 32'(res_b), 4);
        out_ready = 1'b1;
        step();
        chk("sim_cnt", 32'(cnt_b), 1);
        chk("sim_res", 32'(res_b), 6);
        step();
        chk("sim_drain", 32'(cnt_b), 0);
        out_ready = 1'b0;

        // reset with 2 in flight and 2 buffered
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; op1 = 8'(i + 1); op2 = 8'(i + 1);
            step();
        end
        in_valid = 1'b0;
        step(); step();
        chk("mid_cnt_pre", 32'(cnt_b), 2);
        chk("mid_infl_pre", 32'(infl_b), 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_cnt", 32'(cnt_b), 0);
        chk("mid_infl", 32'(infl_b), 0);
        chk("mid_ov", 32'(ov_b), 0);
        chk("mid_rdy", 32'(rdy_b), 1);
        for (int c = 0; c < 5; c++) begin
            step();
            chk("mid_stale", 32'(cnt_b), 0);
        end
        in_valid = 1'b1; op1 = 8'd7; op2 = 8'd1;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        chk("mid_ov_early", 32'(ov_b), 0);
        step();
        chk("mid_ov_new", 32'(ov_b), 1);
        chk("mid_res_new", 32'(res_b), 8);
        chk("mid_cnt_new", 32'(cnt_b), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
